result_bcd_converter: RTL and testbench

- Downstream of the sign/magnitude correcting stage.
- Captures the corrected 9-bit unsigned magnitude and its sign, and converts the magnitude to packed BCD by iterative shift-and-add-3 (double dabble).
- Presents the digits, per-digit leading-zero blank flags and a display sign to the seven-segment display driver.
- One conversion at a time, start/busy/done handshake.

---
 rtl/result_bcd_converter.sv | 127 ++++++++++++
 tb/tb_result_bcd_converter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Result magnitude to packed BCD via iterative shift-and-add-3.
// Drives digits, leading-zero blanks and display sign for the 7-seg driver.
module result_bcd_converter #(
  parameter int MAG_WIDTH  = 9,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MAG_WIDTH-1:0]    mag_in,
  input  logic                    sign_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    neg_out
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = BW + MAG_WIDTH;
  localparam int CW = $clog2(MAG_WIDTH + 1);
  localparam logic [NUM_DIGITS-1:0] BLANK_RST =
    {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  neg_q, neg_d;

  logic [SW-1:0]         adj;
  logic [SW-1:0]         shl;
  logic [BW-1:0]         digits;
  logic                  zero_above;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Nibble correction is on the pre-shift value, no inter-nibble carry.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr_q[MAG_WIDTH+4*i +: 4] >= 4'd5)
        adj[MAG_WIDTH+4*i +: 4] = sr_q[MAG_WIDTH+4*i +: 4] + 4'd3;
    end
    shl    = adj << 1;
    digits = shl[SW-1 -: BW];
  end

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    neg_d      = neg_q;
    zero_above = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d   = {{BW{1'b0}}, mag_in};
          cnt_d  = CW'(MAG_WIDTH);
          sign_d = sign_in;
        end
      end
      SHIFT: begin
        sr_d  = shl;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d = digits;
          for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (digits[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
          end
          blank_d[0] = 1'b0;
          neg_d      = sign_q && (digits != '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  assign bcd_out   = bcd_q;
  assign blank_out = blank_q;
  assign neg_out   = neg_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter with an arithmetic reference model.
// Every negedge compares all outputs against the model.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  mag_in = '0;
  logic        sign_in = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [2:0]  blank_out;
  logic        neg_out;

  int pass_cnt = 0;
  int total = 0;

  result_bcd_converter #(.MAG_WIDTH(9), .NUM_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mag_in(mag_in),
    .sign_in(sign_in), .busy(busy), .done(done), .bcd_out(bcd_out),
    .blank_out(blank_out), .neg_out(neg_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(int m);
    to_bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [2:0] to_blank(int m);
    to_blank = {m < 100, m < 10, 1'b0};
  endfunction

  // Reference: a conversion occupies 9 busy cycles, then 1 done cycle.
  int          m_rem = 0;
  logic        m_done = 1'b0;
  int          m_mag = 0;
  logic        m_sign = 1'b0;
  logic [11:0] m_bcd = '0;
  logic [2:0]  m_blank = 3'b110;
  logic        m_neg = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_done = 0;
      m_bcd = '0; m_blank = 3'b110; m_neg = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_done  = 1;
        m_bcd   = to_bcd(m_mag);
        m_blank = to_blank(m_mag);
        m_neg   = m_sign && (m_mag != 0);
      end
    end else if (start) begin
      m_rem  = 9;
      m_mag  = int'(mag_in);
      m_sign = sign_in;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("bcd", 32'(bcd_out), 32'(m_bcd));
    chk("blank", 32'(blank_out), 32'(m_blank));
    chk("neg", 32'(neg_out), 32'(m_neg));
  endtask

  task automatic convert(int m, logic s, logic [11:0] eb,
                         logic [2:0] ebl, logic en);
    int cyc;
    start = 1; mag_in = 9'(m); sign_in = s;
    tick();
    start = 0; mag_in = ~9'(m); sign_in = ~s;
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd10);
    chk("lit_bcd", 32'(bcd_out), 32'(eb));
    chk("lit_blank", 32'(blank_out), 32'(ebl));
    chk("lit_neg", 32'(neg_out), 32'(en));
    tick();
  endtask

  initial begin
    int dones;
    chk("model_255", 32'(to_bcd(255)), 32'h255);
    chk("model_blank_40", 32'(to_blank(40)), 32'b100);
    tick();
    tick();
    chk("rst_bcd", 32'(bcd_out), 32'h000);
    chk("rst_blank", 32'(blank_out), 32'b110);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0;
    tick();

    convert(255, 0, 12'h255, 3'b000, 0);
    convert(511, 0, 12'h511, 3'b000, 0);
    convert(7, 1, 12'h007, 3'b110, 1);
    convert(40, 0, 12'h040, 3'b100, 0);
    convert(0, 1, 12'h000, 3'b110, 0);
    convert(99, 1, 12'h099, 3'b100, 1);

    // start while busy must be ignored
    start = 1; mag_in = 9'd100; sign_in = 0;
    tick();
    start = 0;
    tick();
    tick();
    start = 1; mag_in = 9'd300;
    tick();
    start = 0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) dones++;
    end
    chk("one_done", 32'(dones), 32'd1);
    chk("ignored_bcd", 32'(bcd_out), 32'h100);
    convert(300, 0, 12'h300, 3'b000, 0);

    // reset mid-conversion
    start = 1; mag_in = 9'd123;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1;
    tick();
    chk("midrst_bcd", 32'(bcd_out), 32'h000);
    chk("midrst_blank", 32'(blank_out), 32'b110);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 0;
    convert(89, 0, 12'h089, 3'b100, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
